// File: rtl/inst_prefetch_queue.sv
// Byte-serial instruction prefetcher: assembles INST_BYTES-wide little-endian words
// into a DEPTH-entry FIFO for decode. Optional counters are enabled with PREFETCH_STATS_EN.
module inst_prefetch_queue #(
  parameter int                ADDR_W     = 17,
  parameter int                INST_BYTES = 4,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pc_changed,
  input  logic [ADDR_W-1:0]       pc_new,
  input  logic                    mem_busy,
  input  logic [7:0]              mem_din,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [8*INST_BYTES-1:0] inst_o,
  output logic [ADDR_W-1:0]       inst_pc_o
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]             stat_fetched,
  output logic [15:0]             stat_flushes,
  output logic [31:0]             stat_stall
`endif
);

  localparam int IW    = 8 * INST_BYTES;
  localparam int IDX_W = $clog2(INST_BYTES + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = IW + ADDR_W;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(INST_BYTES - 1);
  localparam logic [IDX_W-1:0]  FULL_IDX = IDX_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_BYTES);
  localparam logic [CNT_W:0]    DEPTH_W  = (CNT_W + 1)'(DEPTH);

  // Fetch engine state
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              wip_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              pending_reg;
  logic [IDX_W-1:0]  cap_idx_reg;
  logic [ADDR_W-1:0] mem_a_reg;

  // FIFO state
  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              inst_valid_reg;
  logic [IW-1:0]     inst_o_reg;
  logic [ADDR_W-1:0] inst_pc_reg;

  logic              pop;
  logic              last_cap;
  logic              word_free;
  logic              room;
  logic              start_en;
  logic              cont_en;
  logic              issue;
  logic [CNT_W-1:0]  count_eff;
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] issue_addr;
  logic [IW-1:0]     push_word;
  logic [ENT_W-1:0]  push_entry;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [ENT_W-1:0]  head_next;

  assign pop       = inst_valid_reg & inst_ready;
  assign last_cap  = pending_reg && (cap_idx_reg == LAST_IDX);
  assign word_free = !wip_reg || last_cap;
  assign count_eff = count_reg - CNT_W'(pop);

  // A word in flight reserves a slot, so a started word can always be pushed.
  assign room = ({1'b0, count_eff} + {{CNT_W{1'b0}}, wip_reg}) < DEPTH_W;

  assign start_en = word_free && room && !mem_busy && !pc_changed && !rst;
  assign cont_en  = wip_reg && (idx_reg != FULL_IDX) && !mem_busy && !pc_changed && !rst;
  assign issue    = start_en || cont_en;

  // When the last byte lands this cycle, fetch_pc still names the finishing word.
  assign start_pc   = last_cap ? (fetch_pc_reg + PC_STEP) : fetch_pc_reg;
  assign issue_addr = start_en ? start_pc : (fetch_pc_reg + ADDR_W'(idx_reg));
  assign mem_a      = issue ? issue_addr : mem_a_reg;
  assign mem_wr     = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < INST_BYTES; gi++) begin : g_lane
      if (gi < INST_BYTES - 1) begin : g_reg
        logic [7:0] byte_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            byte_reg <= '0;
          end else if (pending_reg && !pc_changed && (cap_idx_reg == IDX_W'(gi))) begin
            byte_reg <= mem_din;
          end
        end
        assign push_word[8*gi +: 8] = byte_reg;
      end else begin : g_last
        // The top byte goes straight from the port into the FIFO entry.
        assign push_word[8*gi +: 8] = mem_din;
      end
    end
  endgenerate

  assign push_entry  = {push_word, fetch_pc_reg};
  assign cnt_next    = count_reg - CNT_W'(pop) + CNT_W'(last_cap);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign head_next   = (last_cap && (count_eff == '0)) ? push_entry : fifo_mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      wip_reg      <= 1'b0;
      idx_reg      <= '0;
      pending_reg  <= 1'b0;
      cap_idx_reg  <= '0;
      mem_a_reg    <= '0;
    end else if (pc_changed) begin
      fetch_pc_reg <= pc_new;
      wip_reg      <= 1'b0;
      idx_reg      <= '0;
      pending_reg  <= 1'b0;
      cap_idx_reg  <= '0;
      mem_a_reg    <= mem_a;
    end else begin
      mem_a_reg   <= mem_a;
      pending_reg <= issue;
      if (issue) begin
        cap_idx_reg <= start_en ? '0 : idx_reg;
      end
      if (last_cap) begin
        fetch_pc_reg <= fetch_pc_reg + PC_STEP;
      end
      if (start_en) begin
        wip_reg <= 1'b1;
        idx_reg <= IDX_W'(1);
      end else if (cont_en) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end else if (last_cap) begin
        wip_reg <= 1'b0;
        idx_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (last_cap && !pc_changed && !rst) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  // Output stage is the registered FIFO head; a push into an empty queue bypasses the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      inst_valid_reg <= 1'b0;
      inst_o_reg     <= '0;
      inst_pc_reg    <= '0;
    end else if (pc_changed) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_reg + PTR_W'(last_cap);
      count_reg      <= cnt_next;
      inst_valid_reg <= (cnt_next != '0);
      if (cnt_next != '0) begin
        inst_o_reg  <= head_next[ENT_W-1:ADDR_W];
        inst_pc_reg <= head_next[ADDR_W-1:0];
      end
    end
  end

  assign inst_valid = inst_valid_reg;
  assign inst_o     = inst_o_reg;
  assign inst_pc_o  = inst_pc_reg;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_reg;
  logic [15:0] stat_flushes_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_reg <= '0;
      stat_flushes_reg <= '0;
      stat_stall_reg   <= '0;
    end else begin
      if (last_cap && !pc_changed && (stat_fetched_reg != '1)) begin
        stat_fetched_reg <= stat_fetched_reg + 32'd1;
      end
      if (pc_changed && (stat_flushes_reg != '1)) begin
        stat_flushes_reg <= stat_flushes_reg + 16'd1;
      end
      if (word_free && !pc_changed && (!room || mem_busy) && (stat_stall_reg != '1)) begin
        stat_stall_reg <= stat_stall_reg + 32'd1;
      end
    end
  end

  assign stat_fetched = stat_fetched_reg;
  assign stat_flushes = stat_flushes_reg;
  assign stat_stall   = stat_stall_reg;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: a default 4-byte/4-deep instance plus a
// free-running 2-byte/2-deep instance, both fed by a 1-cycle-latency byte memory.
module tb_inst_prefetch_queue;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pc_changed;
  logic [AW-1:0] pc_new;
  logic          mem_busy;
  logic          inst_ready;
  logic [7:0]    mem_din;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          inst_valid;
  logic [31:0]   inst_o;
  logic [AW-1:0] inst_pc_o;

  logic [7:0]    mem_din2;
  logic [AW-1:0] mem_a2;
  logic          mem_wr2;
  logic          inst_valid2;
  logic [15:0]   inst_o2;
  logic [AW-1:0] inst_pc_o2;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall, stat_fetched2, stat_stall2;
  logic [15:0] stat_flushes, stat_flushes2;
`endif

  inst_prefetch_queue #(.ADDR_W(AW), .INST_BYTES(4), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .pc_changed(pc_changed), .pc_new(pc_new),
    .mem_busy(mem_busy), .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
`ifdef PREFETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes), .stat_stall(stat_stall)
`endif
  );

  inst_prefetch_queue #(.ADDR_W(AW), .INST_BYTES(2), .DEPTH(2), .RESET_PC('0)) dut2 (
    .clk(clk), .rst(rst), .pc_changed(1'b0), .pc_new('0),
    .mem_busy(1'b0), .mem_din(mem_din2), .mem_a(mem_a2), .mem_wr(mem_wr2),
    .inst_valid(inst_valid2), .inst_ready(1'b1), .inst_o(inst_o2), .inst_pc_o(inst_pc_o2)
`ifdef PREFETCH_STATS_EN
    , .stat_fetched(stat_fetched2), .stat_flushes(stat_flushes2), .stat_stall(stat_stall2)
`endif
  );

  // Memory image: address 0 holds 0x13, 1..3 are zero, everything else is low byte + 0x30.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    if (a == '0) return 8'h13;
    if (a < AW'(4)) return 8'h00;
    return a[7:0] + 8'h30;
  endfunction

  function automatic logic [31:0] word4(input logic [AW-1:0] pc);
    return {mem_byte(pc + AW'(3)), mem_byte(pc + AW'(2)), mem_byte(pc + AW'(1)), mem_byte(pc)};
  endfunction

  function automatic logic [15:0] word2(input logic [AW-1:0] pc);
    return {mem_byte(pc + AW'(1)), mem_byte(pc)};
  endfunction

  always @(posedge clk) begin
    mem_din  <= mem_byte(mem_a);
    mem_din2 <= mem_byte(mem_a2);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int changes;
    rst = 1'b1; pc_changed = 1'b0; pc_new = '0; mem_busy = 1'b0; inst_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_o", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("rst_mem_a", 64'(mem_a), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);

    // First fetch latency on dut, steady 2-byte throughput on dut2
    rst = 1'b0;
    #1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc <= 4) chk("first_mem_a", 64'(mem_a), 64'(cyc));
      if (cyc == 4) chk("first_valid_early", 64'(inst_valid), 64'd0);
      if (cyc == 5) begin
        chk("first_valid", 64'(inst_valid), 64'd1);
        chk("first_inst_o", 64'(inst_o), 64'h13);
        chk("first_inst_pc", 64'(inst_pc_o), 64'd0);
      end
      chk("d2_valid", 64'(inst_valid2), 64'((cyc >= 3) && (cyc % 2 == 1)));
      if ((cyc >= 3) && (cyc % 2 == 1)) begin
        chk("d2_inst_pc", 64'(inst_pc_o2), 64'(cyc - 3));
        chk("d2_inst_o", 64'(inst_o2), 64'(word2(AW'(cyc - 3))));
      end
`ifdef PREFETCH_STATS_EN
      if (cyc == 21) begin
        chk("d2_stat_fetched", 64'(stat_fetched2), 64'd10);
        chk("d2_stat_flushes", 64'(stat_flushes2), 64'd0);
      end
`endif
      tick();
    end

    // Backpressure: four words fill the FIFO, then the engine idles
    rst = 1'b1; tick();
    rst = 1'b0; inst_ready = 1'b0;
    #1;
    changes = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc >= 20 && mem_a != AW'(15)) changes++;
      if (cyc == 39) begin
        chk("full_mem_a", 64'(mem_a), 64'd15);
        chk("full_valid", 64'(inst_valid), 64'd1);
      end
      tick();
    end
    chk("full_hold_changes", 64'(changes), 64'd0);
    inst_ready = 1'b1;
    #1;
    chk("drain_restart_mem_a", 64'(mem_a), 64'd16);
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 64'(inst_valid), 64'd1);
      chk("drain_inst_pc", 64'(inst_pc_o), 64'(4 * k));
      chk("drain_inst_o", 64'(inst_o), 64'(word4(AW'(4 * k))));
      tick();
    end
    chk("drain_empty", 64'(inst_valid), 64'd0);
    tick();
    chk("drain_next_pc", 64'(inst_pc_o), 64'd16);
    chk("drain_next_o", 64'(inst_o), 64'(word4(AW'(16))));

    // mem_busy while byte 2 is due
    rst = 1'b1; tick();
    rst = 1'b0; inst_ready = 1'b1;
    #1;
    chk("busy_mem_a0", 64'(mem_a), 64'd0);
    tick();
    chk("busy_mem_a1", 64'(mem_a), 64'd1);
    tick();
    mem_busy = 1'b1;
    #1;
    chk("busy_hold", 64'(mem_a), 64'd1);
    tick(); tick(); tick();
    mem_busy = 1'b0;
    #1;
    chk("busy_resume2", 64'(mem_a), 64'd2);
    tick();
    chk("busy_resume3", 64'(mem_a), 64'd3);
    tick();
    chk("busy_valid_early", 64'(inst_valid), 64'd0);
    tick();
    chk("busy_valid", 64'(inst_valid), 64'd1);
    chk("busy_inst_o", 64'(inst_o), 64'h13);

    // Redirect with two words queued and byte 1 pending
    rst = 1'b1; tick();
    rst = 1'b0; inst_ready = 1'b0;
    #1;
    for (int cyc = 0; cyc < 10; cyc++) tick();
    chk("redir_pre_valid", 64'(inst_valid), 64'd1);
    chk("redir_pre_pc", 64'(inst_pc_o), 64'd0);
    pc_changed = 1'b1; pc_new = AW'(17'h100);
    tick();
    pc_changed = 1'b0; inst_ready = 1'b1;
    #1;
    chk("redir_valid_drop", 64'(inst_valid), 64'd0);
    chk("redir_mem_a", 64'(mem_a), 64'h100);
    tick(); tick(); tick(); tick();
    chk("redir_valid_early", 64'(inst_valid), 64'd0);
    tick();
    chk("redir_valid", 64'(inst_valid), 64'd1);
    chk("redir_inst_pc", 64'(inst_pc_o), 64'h100);
    chk("redir_inst_o", 64'(inst_o), 64'(word4(AW'(17'h100))));

    // Redirect near the top of the address space; overrides this cycle's pop
    pc_changed = 1'b1; pc_new = AW'(17'h1FFFE);
    tick();
    pc_changed = 1'b0;
    #1;
    chk("wrap_valid_drop", 64'(inst_valid), 64'd0);
    chk("wrap_mem_a0", 64'(mem_a), 64'h1FFFE);
    tick();
    chk("wrap_mem_a1", 64'(mem_a), 64'h1FFFF);
    tick();
    chk("wrap_mem_a2", 64'(mem_a), 64'h0);
    tick();
    chk("wrap_mem_a3", 64'(mem_a), 64'h1);
    tick();
    chk("wrap_next_word_a", 64'(mem_a), 64'h2);
    tick();
    chk("wrap_valid", 64'(inst_valid), 64'd1);
    chk("wrap_inst_pc", 64'(inst_pc_o), 64'h1FFFE);
    chk("wrap_inst_o", 64'(inst_o), 64'h00132F2E);
    tick(); tick(); tick(); tick();
    chk("wrap_next_valid", 64'(inst_valid), 64'd1);
    chk("wrap_next_pc", 64'(inst_pc_o), 64'h2);
    chk("wrap_next_o", 64'(inst_o), 64'h35340000);
`ifdef PREFETCH_STATS_EN
    chk("stat_flushes", 64'(stat_flushes), 64'd2);
    chk("stat_fetched", 64'(stat_fetched), 64'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Parametrised successor to the byte-serial instruction fetcher.
- Assembles INST_BYTES-wide little-endian instructions from a byte-wide, 1-cycle-latency memory port and queues them in a DEPTH-entry prefetch FIFO.
- Presents the queue to decode with a valid/ready handshake and tags each instruction with its PC.
- Sits between the PC/branch logic and decode. It yields the memory port to data accesses through mem_busy and flushes on a PC redirect.

Parameters:
- ADDR_W, 17, byte address width; mem_a and PCs wrap modulo 2^ADDR_W.
- INST_BYTES, 4, bytes per instruction (legal 1..8); inst_o width = 8*INST_BYTES.
- DEPTH, 4, prefetch FIFO entries (power of 2, 2..16).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_changed  in  1  redirect strobe; flush and refetch from pc_new.
- pc_new  in  ADDR_W  redirect target, sampled when pc_changed=1.
- mem_busy  in  1  data side owns memory port this cycle; no fetch issue.
- mem_din  in  8  read byte, valid the cycle after its address.
- mem_a  out  ADDR_W  fetch byte address.
- mem_wr  out  1  always 0 (read); never drives a write.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head when inst_valid & inst_ready.
- inst_o  out  8*INST_BYTES  head instruction; byte k = mem[pc+k].
- inst_pc_o  out  ADDR_W  PC of head instruction.

Behaviour:
- Reset (rst=1 at edge): FIFO empty, inst_valid=0, inst_o=0, inst_pc_o=0, mem_a=0, mem_wr=0, byte counter=0, no pending read, fetch_pc=RESET_PC. Reset mid-word discards the partial word.
- Issue rule: issue one byte address per cycle when !mem_busy and the engine is active.
- A new word (byte 0) starts only if fifo_count + word_in_progress < DEPTH. Otherwise the engine idles and mem_a holds its last value.
- Byte k of a word goes to address fetch_pc+k. A one-bit pending flag marks an issued read. Data is captured into byte lane k on the next cycle only if pending is set.
- mem_busy=1 suppresses the issue. The following cycle has no capture, and the word resumes at the same byte index.
- Completion: capture of byte INST_BYTES-1 pushes {bytes, fetch_pc} into the FIFO. fetch_pc advances by INST_BYTES with modulo wrap.
- Byte 0 of the next word may issue in the same cycle as the last byte capture, giving a peak throughput of 1 instruction per INST_BYTES cycles.
- Latency: with the FIFO empty and no stalls, inst_valid rises INST_BYTES+1 cycles after byte 0 is issued.
- FIFO: circular, with count 0..DEPTH. A push and a pop in the same cycle are both honoured. inst_o and inst_pc_o are registered from the head and are stable while inst_valid=1 and inst_ready=0.
- Redirect: pc_changed=1 at edge t empties the FIFO, discards the partial word and the pending byte, and sets fetch_pc=pc_new.
  - inst_valid=0 from t+1.
  - mem_a=pc_new is issued at t+1 unless mem_busy.
  - pc_changed overrides a same-cycle pop or push; the popped or pushed word is dropped.
- rst has priority over pc_changed.
- Wrap-around: an address of 2^ADDR_W-1 followed by +1 gives 0, within a word and across words.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined: adds outputs stat_fetched (32-bit, count of FIFO pushes), stat_flushes (16-bit, count of pc_changed cycles) and stat_stall (32-bit, count of cycles where a word start was blocked by a full FIFO or mem_busy). All three reset to 0 and saturate at their maximum value.
- Not defined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset with mem[0..3]=13,00,00,00, inst_ready=1 -> inst_valid at cycle 5 after reset release, inst_o=0x00000013, inst_pc_o=0; mem_a sequence 0,1,2,3,4.
- inst_ready=0 for 40 cycles, DEPTH=4 -> exactly 4 pushes, then mem_a holds and no further issue. Pops then return PCs 0,4,8,12 in order with the correct words.
- mem_busy=1 for 3 cycles while byte 2 is due -> mem_a resumes at pc+2. inst_o is unchanged versus the no-stall case, with latency +3.
- pc_changed=1, pc_new=0x100 while 2 words are queued and byte 1 is pending -> inst_valid=0 next cycle, mem_a=0x100 next cycle, and the first valid output has inst_pc_o=0x100.
- pc_new=0x1FFFE, INST_BYTES=4 -> addresses 1FFFE,1FFFF,0,1. inst_o is assembled in that order, and the next word's PC is 0x00002.
- INST_BYTES=2, DEPTH=2, steady inst_ready=1 -> one instruction every 2 cycles. With PREFETCH_STATS_EN, stat_fetched=10 after 10 pushes and stat_flushes=0.
